// File: rtl/md_board_multi.sv
// Multi-ring magical dartboard: serial score load, a burst of darts scored with ring rotate/swap, one result pulse.
// Latency: out_valid rises on the edge after the first low in_valid_2 sample that follows a scored dart, and lasts one cycle.
// Backpressure: none. Beats are sampled when their valid is high in the accepting state; beats in other states, and darts past MAX_DARTS, are dropped.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid_1, in_score      score beat stream (RINGS*SECTORS beats per game)
//   in_valid_2, in_dart       dart beat; in_dart = {ring index, sector offset}
//   in_rotation, rotate_flag  rotation step (0 = swap) and direction (1 = ccw)
//   in_ring                   ring rotated or swapped by this dart
//   out_valid, out_sum, out_count  single-cycle result; sum and count are zero otherwise
module md_board_multi #(
  parameter int RINGS     = 2,
  parameter int SECTORS   = 8,
  parameter int SCORE_W   = 3,
  parameter int MAX_DARTS = 16,
  parameter int SUM_W     = 7,
  parameter int CNT_W     = 5,
  localparam int SW       = $clog2(SECTORS),
  localparam int RW       = ($clog2(RINGS) > 0) ? $clog2(RINGS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_1,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_valid_2,
  input  logic [RW+SW-1:0]   in_dart,
  input  logic [SW-1:0]      in_rotation,
  input  logic               rotate_flag,
  input  logic [RW-1:0]      in_ring,
  output logic               out_valid,
  output logic [SUM_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count
);

  localparam int TOTAL = RINGS * SECTORS;
  // Flat score index is {bank, sector}; SECTORS is a power of two so this
  // equals bank*SECTORS + sector, which is also the beat number at load time.
  localparam int IW    = RW + SW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      beat_q, beat_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SW-1:0]      offset_q [RINGS];
  logic [SW-1:0]      offset_d [RINGS];
  logic [RW-1:0]      bank_q   [RINGS];
  logic [RW-1:0]      bank_d   [RINGS];
  logic [SCORE_W-1:0] score_q  [TOTAL];
  logic [SCORE_W-1:0] score_d  [TOTAL];
  logic               out_valid_q, out_valid_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  // Dart decode and hit lookup, all from pre-update state.
  logic [RW-1:0]      hit_ring;
  logic [SW-1:0]      hit_off;
  logic [SW-1:0]      hit_sec;
  logic [SCORE_W-1:0] hit_score;
  logic [RW-1:0]      ring_next;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    sum_d       = sum_q;
    count_d     = count_q;
    offset_d    = offset_q;
    bank_d      = bank_q;
    score_d     = score_q;
    out_valid_d = 1'b0;
    out_sum_d   = '0;
    out_count_d = '0;

    hit_ring  = in_dart[IW-1:SW];
    hit_off   = in_dart[SW-1:0];
    // SW-bit add wraps modulo SECTORS for free.
    hit_sec   = offset_q[hit_ring] + hit_off;
    hit_score = score_q[{bank_q[hit_ring], hit_sec}];
    // Swap partner of in_ring: the next ring, wrapping to ring 0.
    ring_next = (in_ring == RW'(RINGS - 1)) ? '0 : in_ring + RW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid_1) begin
          score_d[0] = in_score;
          beat_d     = IW'(1);
          sum_d      = '0;
          count_d    = '0;
          for (int r = 0; r < RINGS; r++) begin
            offset_d[r] = '0;
            bank_d[r]   = RW'(r);
          end
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Gaps (in_valid_1 low) leave the beat counter where it is.
        if (in_valid_1) begin
          score_d[beat_q] = in_score;
          if (beat_q == IW'(TOTAL - 1)) begin
            beat_d  = '0;
            state_d = S_PLAY;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end

      S_PLAY: begin
        if (in_valid_2) begin
          if (count_q < CNT_W'(MAX_DARTS)) begin
            sum_d   = sum_q + SUM_W'(hit_score);
            count_d = count_q + CNT_W'(1);
            if (in_rotation != '0) begin
              if (rotate_flag) begin
                offset_d[in_ring] = offset_q[in_ring] + in_rotation;
              end else begin
                offset_d[in_ring] = offset_q[in_ring] - in_rotation;
              end
            end else begin
              // Zero step swaps the whole (bank, offset) view with the next ring.
              bank_d[in_ring]     = bank_q[ring_next];
              bank_d[ring_next]   = bank_q[in_ring];
              offset_d[in_ring]   = offset_q[ring_next];
              offset_d[ring_next] = offset_q[in_ring];
            end
          end
        end else if (count_q != '0) begin
          // A quiet cycle ends the burst only once at least one dart landed.
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_sum_d   = sum_q;
          out_count_d = count_q;
        end
      end

      S_OUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      for (int r = 0; r < RINGS; r++) begin
        offset_q[r] <= '0;
        bank_q[r]   <= RW'(r);
      end
      for (int i = 0; i < TOTAL; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      offset_q    <= offset_d;
      bank_q      <= bank_d;
      score_q     <= score_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule
